// File: rtl/accel_result_drain.sv
// Drain side of the systolic accelerator: snapshots the N*N result matrix on a
// rising acc_done and streams it out one word per valid/ready handshake.
// Optional build macro ACCEL_DRAIN_COL_MAJOR_EN selects column-major emission order.
module accel_result_drain #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 32,
  localparam int unsigned IW = $clog2(N*N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_done,
  input  logic [N*N*W-1:0] result_flat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             drain_done,
  output logic             overrun
);

  localparam int unsigned NN = N*N;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] nxt;
  logic          acc_done_q;
  logic          done_rise;
  logic          cap;
  logic          valid_d, busy_d, last_d, dd_d, ovr_d;
  logic [W-1:0]  data_d;
  logic [IW-1:0] idx_d;
  logic [W-1:0]  buffer [NN];

  // Map an emission position to the row-major element index it carries.
  function automatic logic [IW-1:0] emit_idx(input logic [IW-1:0] p);
`ifdef ACCEL_DRAIN_COL_MAJOR_EN
    int unsigned pi;
    pi = 32'(p);
    return IW'((pi % N) * N + pi / N);
`else
    return p;
`endif
  endfunction

  assign done_rise = acc_done & ~acc_done_q;
  assign nxt       = ptr_q + IW'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cap     = 1'b0;
    valid_d = out_valid;
    busy_d  = busy;
    last_d  = out_last;
    data_d  = out_data;
    idx_d   = out_idx;
    dd_d    = 1'b0;
    ovr_d   = overrun;
    case (state_q)
      IDLE: begin
        if (done_rise) begin
          cap     = 1'b1;
          state_d = SEND;
          ptr_d   = '0;
          ovr_d   = 1'b0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          // position 0 is element 0 in either emission order
          data_d  = result_flat[W-1:0];
          idx_d   = '0;
          last_d  = (NN == 1);
        end
      end
      SEND: begin
        if (done_rise) ovr_d = 1'b1;
        if (out_ready) begin
          if (ptr_q == IW'(NN-1)) begin
            state_d = IDLE;
            ptr_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            last_d  = 1'b0;
            data_d  = '0;
            idx_d   = '0;
            dd_d    = 1'b1;
          end else begin
            ptr_d   = nxt;
            idx_d   = emit_idx(nxt);
            data_d  = buffer[emit_idx(nxt)];
            last_d  = (nxt == IW'(NN-1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      acc_done_q <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      out_idx    <= '0;
      drain_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      acc_done_q <= acc_done;
      out_valid  <= valid_d;
      busy       <= busy_d;
      out_last   <= last_d;
      out_data   <= data_d;
      out_idx    <= idx_d;
      drain_done <= dd_d;
      overrun    <= ovr_d;
    end
  end

  // Snapshot storage; contents are irrelevant until the first capture.
  always_ff @(posedge clk) begin
    if (cap) begin
      for (int k = 0; k < int'(NN); k++) buffer[k] <= result_flat[k*W +: W];
    end
  end

endmodule

// File: tb/tb_accel_result_drain.sv
// Randomized and directed bench for accel_result_drain against a queue-based model.
module tb_accel_result_drain;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NN = N*N;
  localparam int IW = $clog2(NN);

  logic             clk = 1'b0;
  logic             rst;
  logic             acc_done;
  logic [NN*W-1:0]  result_flat;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [IW-1:0]    out_idx;
  logic             out_last;
  logic             busy;
  logic             drain_done;
  logic             overrun;

  int n_chk  = 0;
  int n_fail = 0;

  accel_result_drain #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .acc_done(acc_done), .result_flat(result_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy),
    .drain_done(drain_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Emission position -> row-major element index
  function automatic int pos2k(input int p);
`ifdef ACCEL_DRAIN_COL_MAJOR_EN
    return (p % N) * N + p / N;
`else
    return p;
`endif
  endfunction

  // Model: pending words of the current drain, oldest first
  int   mq_data[$];
  int   mq_idx[$];
  logic m_prev;
  logic m_dd;
  logic m_ovr;
  int   m_hs;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_data.delete(); mq_idx.delete();
      m_prev = 1'b0; m_dd = 1'b0; m_ovr = 1'b0;
    end else begin
      logic rise;
      rise   = acc_done & ~m_prev;
      m_prev = acc_done;
      m_dd   = 1'b0;
      if (mq_data.size() > 0) begin
        if (rise) m_ovr = 1'b1;
        if (out_ready) begin
          void'(mq_data.pop_front()); void'(mq_idx.pop_front());
          m_hs++;
          if (mq_data.size() == 0) m_dd = 1'b1;
        end
      end else if (rise) begin
        m_ovr = 1'b0;
        for (int p = 0; p < NN; p++) begin
          mq_idx.push_back(pos2k(p));
          mq_data.push_back(int'(result_flat[pos2k(p)*W +: W]));
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_idx", 64'(out_idx), 64'd0);
      chk("rst_last", 64'(out_last), 64'd0);
      chk("rst_dd", 64'(drain_done), 64'd0);
      chk("rst_ovr", 64'(overrun), 64'd0);
    end else begin
      logic v;
      v = (mq_data.size() > 0);
      chk("valid", 64'(out_valid), 64'(v));
      chk("busy", 64'(busy), 64'(v));
      chk("drain_done", 64'(drain_done), 64'(m_dd));
      chk("overrun", 64'(overrun), 64'(m_ovr));
      if (v) begin
        chk("data", 64'(out_data), 64'(unsigned'(mq_data[0])));
        chk("idx", 64'(out_idx), 64'(mq_idx[0]));
        chk("last", 64'(out_last), 64'(mq_data.size() == 1));
      end
    end
  end

  task automatic set_pattern();
    for (int k = 0; k < NN; k++) result_flat[k*W +: W] = 32'h100 + 32'(k);
  endtask

  // Rising edge on acc_done; returns at the negedge after the capture edge
  task automatic pulse_done();
    @(negedge clk); acc_done = 1'b1;
    @(negedge clk); acc_done = 1'b0;
  endtask

  task automatic wait_dd(input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (drain_done) begin seen = 1'b1; break; end
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  task automatic wait_hs(input int base, input int n, input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (m_hs - base >= n) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk(name, 64'(seen), 64'd1);
  endtask

  initial begin
    int base, cyc;
    m_hs = 0;
    rst = 1'b1; acc_done = 1'b0; out_ready = 1'b0;
    set_pattern();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic drain with ready held high
    out_ready = 1'b1;
    base = m_hs;
    pulse_done();
    chk("t1_first_valid", 64'(out_valid), 64'd1);
    chk("t1_first_data", 64'(out_data), 64'h100);
    chk("t1_first_idx", 64'(out_idx), 64'd0);
    cyc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); cyc++;
      if (cyc == 1) begin
`ifdef ACCEL_DRAIN_COL_MAJOR_EN
        chk("t1_second_idx", 64'(out_idx), 64'd4);
        chk("t1_second_data", 64'(out_data), 64'h104);
`else
        chk("t1_second_idx", 64'(out_idx), 64'd1);
        chk("t1_second_data", 64'(out_data), 64'h101);
`endif
      end
      if (drain_done) break;
    end
    chk("t1_dd_latency", 64'(cyc), 64'd16);
    chk("t1_hs", 64'(m_hs - base), 64'd16);

    // Backpressure: ready pattern 1,0,0 repeating
    base = m_hs;
    pulse_done();
    for (int i = 0; i < 100; i++) begin
      out_ready = (i % 3 == 0);
      @(negedge clk);
      if (drain_done) break;
    end
    chk("t2_hs", 64'(m_hs - base), 64'd16);
    out_ready = 1'b1;

    // Level held high, source changes after capture
    base = m_hs;
    @(negedge clk); acc_done = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NN; k++) result_flat[k*W +: W] = 32'hDEADBEEF;
    repeat (38) @(negedge clk);
    chk("t3_hs", 64'(m_hs - base), 64'd16);
    chk("t3_overrun", 64'(overrun), 64'd0);
    acc_done = 1'b0;
    set_pattern();
    @(negedge clk);

    // Overrun at word 5, then back-to-back capture in the drain_done cycle
    base = m_hs;
    pulse_done();
    wait_hs(base, 5, "t4_hs5_timeout");
    acc_done = 1'b1;
    @(negedge clk); acc_done = 1'b0;
    chk("t4_overrun_set", 64'(overrun), 64'd1);
    wait_dd("t4_dd_timeout");
    acc_done = 1'b1;
    @(negedge clk); acc_done = 1'b0;
    chk("t5_b2b_valid", 64'(out_valid), 64'd1);
    chk("t5_b2b_overrun", 64'(overrun), 64'd0);
    wait_dd("t5_dd_timeout");

    // Reset mid-drain
    base = m_hs;
    pulse_done();
    wait_hs(base, 3, "t6_hs3_timeout");
    acc_done = 1'b1;
    @(negedge clk); acc_done = 1'b0;
    wait_hs(base, 7, "t6_hs7_timeout");
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_overrun", 64'(overrun), 64'd0);
    @(negedge clk); rst = 1'b0;
    pulse_done();
    chk("t6_restart_idx", 64'(out_idx), 64'd0);
    chk("t6_restart_data", 64'(out_data), 64'h100);
    wait_dd("t6_dd_timeout");

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      out_ready = ($urandom % 4) != 0;
      if ($urandom % 12 == 0) acc_done = ~acc_done;
      if ($urandom % 8 == 0)
        for (int k = 0; k < NN; k++) result_flat[k*W +: W] = $urandom;
      if ($urandom % 600 == 0) begin
        #2 rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end
    end
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_result_drain.md
Name: accel_result_drain

Overview:
- Drain side of the systolic accelerator.
- When the accelerator asserts done, the block snapshots the N*N result matrix from result_flat into a local buffer.
- It then streams the elements out one W-bit word at a time over a valid/ready handshake, toward the PCPI/CPU read-back path or a memory writer.
- It is the counterpart of the input streamer that feeds A/B words into the core.

Parameters:
- N, 4, matrix dimension (result is N x N)
- W, 32, element width in bits
- IW, $clog2(N*N), width of the element index output (derived, not overridden)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- acc_done  in  1  accelerator done level/pulse; its rising edge triggers capture
- result_flat  in  N*N*W  result matrix; element k = result_flat[k*W +: W], k = row*N+col
- out_valid  out  1  out_data/out_idx/out_last are valid
- out_ready  in  1  downstream accepts the word when out_valid & out_ready
- out_data  out  W  current result element
- out_idx  out  IW  row-major index k of the element on out_data
- out_last  out  1  high with the final element of the matrix
- busy  out  1  high while a matrix is captured and not fully drained
- drain_done  out  1  one-cycle pulse after the final handshake
- overrun  out  1  sticky: an acc_done rising edge arrived while busy

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0, acc_done_q=0. out_valid, out_last, busy, drain_done and overrun are all 0. out_data=0, out_idx=0. Buffer contents are don't-care.
- Edge detect: acc_done_q <= acc_done every cycle. done_rise = acc_done & ~acc_done_q. A level held high triggers only one capture.
- States: IDLE and SEND.
- IDLE:
  - out_valid=0, busy=0.
  - On done_rise: buffer <= result_flat (entire matrix, same edge), ptr <= 0, overrun <= 0, state <= SEND.
- SEND:
  - busy=1, out_valid=1.
  - out_data = buffer element at emission position ptr; out_idx = that element's row-major index.
  - out_last = (ptr == N*N-1).
  - On handshake (out_valid & out_ready): if ptr == N*N-1, then state <= IDLE, ptr <= 0, drain_done <= 1. Otherwise ptr <= ptr+1.
- Latency:
  - out_valid rises in the cycle after the capture edge.
  - With out_ready held high, N*N words go out on N*N consecutive cycles.
  - drain_done pulses in the cycle after the last handshake; state is IDLE in that cycle.
- Backpressure: while out_valid & ~out_ready, out_data, out_idx and out_last hold stable. out_valid never deasserts before acceptance.
- Buffering: result_flat may change freely after capture; the outputs reflect only the snapshot.
- done_rise while in SEND: ignored. The buffer is not overwritten, overrun <= 1, and the drain continues unaffected.
- done_rise in the drain_done cycle (state IDLE): accepted as a normal capture. drain_done is still 1 for that cycle.
- done_rise in the same cycle as the final handshake: still state SEND, so it is treated as an overrun.
- drain_done is 0 in every cycle other than the one described above.
- Reset mid-drain: immediate abort. All outputs return to reset values; no drain_done.
- ptr counts 0..N*N-1 only; no wrap beyond the last element.

Optional Feature:
- Macro: ACCEL_DRAIN_COL_MAJOR_EN
- Defined: emission order is column-major. Emission position p maps to k = (p%N)*N + p/N, and out_idx reports that k. For N=4 the out_idx sequence is 0,4,8,12,1,5,...,15.
- Undefined: emission order is row-major, so out_idx = ptr, sequence 0,1,2,...,N*N-1.
- Handshake, out_last, drain_done and timing are identical in both builds.

Test Plan:
- Basic row-major drain: N=4, W=32, result_flat element k = 32'h100+k, acc_done pulse, out_ready=1 -> out_valid rises the next cycle. 16 words 0x100..0x10F follow with out_idx 0..15 on consecutive cycles. out_last only on 0x10F. drain_done pulses once, the cycle after.
- Backpressure: same matrix, out_ready toggled 1,0,0,1,... -> each word held stable while ready=0. No word duplicated or skipped. Exactly 16 handshakes, then drain_done.
- Snapshot/level: acc_done held high 40 cycles and result_flat changed to all 0xDEADBEEF after capture -> single drain of the original 0x100..0x10F values. overrun stays 0.
- Overrun: second acc_done rising edge at word 5 of a drain -> overrun=1 from the next cycle. The remaining words are unchanged. overrun clears on the next capture in IDLE.
- Back-to-back: new acc_done rising edge in the drain_done cycle -> second capture accepted. out_valid is high the following cycle and overrun=0.
- Reset mid-drain: rst asserted at word 7 -> out_valid, busy and overrun are 0 immediately (async). No drain_done. A later acc_done restarts from out_idx 0. Run with ACCEL_DRAIN_COL_MAJOR_EN defined as well -> out_idx order 0,4,8,12,1,... with matching data 0x100+k.
